// File: rtl/serial_divider_6bit_if.sv
// Handshake and data bundle for the 6-bit serial divider.
interface serial_divider_6bit_if;
  logic       start;
  logic [5:0] dividend;
  logic [5:0] divisor;
  logic       busy;
  logic       done;
  logic [5:0] quotient;
  logic [5:0] remainder;
  logic       div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/serial_divider_6bit.sv
// 6-bit unsigned restoring divider, one quotient bit per clock, MSB first.
// A zero divisor skips the iteration and reports quotient=3F, remainder=dividend.
module serial_divider_6bit (
  input  logic                 clk,
  input  logic                 rst,
  serial_divider_6bit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;

  logic [2:0] cnt;
  logic [5:0] dvd_sh;
  logic [5:0] dvs;
  logic [5:0] rem_w;
  logic [4:0] q_w;
  logic [5:0] quotient_r;
  logic [5:0] remainder_r;
  logic       dbz_r;

  logic [6:0] partial;
  logic [6:0] diff;
  logic       q_bit;
  logic [5:0] rem_next;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (bus.start) state_next = (bus.divisor == '0) ? DONE : CALC;
      CALC: if (cnt == 3'd5) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One restoring step at 7-bit width. The selected value is always below the
  // divisor, so dropping its top bit loses nothing.
  always_comb begin
    partial  = {rem_w, dvd_sh[5]};
    diff     = partial - {1'b0, dvs};
    q_bit    = (partial >= {1'b0, dvs});
    rem_next = 6'(q_bit ? diff : partial);
  end

  // Operand capture, iteration, and result registers (written only on entry to DONE).
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      dvd_sh      <= '0;
      dvs         <= '0;
      rem_w       <= '0;
      q_w         <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            dvd_sh <= bus.dividend;
            dvs    <= bus.divisor;
            rem_w  <= '0;
            q_w    <= '0;
            cnt    <= '0;
            dbz_r  <= (bus.divisor == '0);
            if (bus.divisor == '0) begin
              quotient_r  <= '1;
              remainder_r <= bus.dividend;
            end
          end
        end
        CALC: begin
          rem_w  <= rem_next;
          q_w    <= {q_w[3:0], q_bit};
          dvd_sh <= {dvd_sh[4:0], 1'b0};
          cnt    <= cnt + 3'd1;
          if (cnt == 3'd5) begin
            quotient_r  <= {q_w, q_bit};
            remainder_r <= rem_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state == CALC);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_serial_divider_6bit.sv
// Directed and exhaustive bench for serial_divider_6bit with a result scoreboard.
module tb_serial_divider_6bit;

  logic clk = 1'b0;
  logic rst;
  serial_divider_6bit_if bus ();

  serial_divider_6bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] q;
    logic [5:0] r;
    logic       z;
    int         idx;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [5:0] last_q = '0;
  logic [5:0] last_r = '0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"}, 16'(bus.busy), 16'd0);
    chk({tag, " done"}, 16'(bus.done), 16'd0);
    chk({tag, " quotient"}, 16'(bus.quotient), 16'd0);
    chk({tag, " remainder"}, 16'(bus.remainder), 16'd0);
    chk({tag, " div_by_zero"}, 16'(bus.div_by_zero), 16'd0);
  endtask

  // Launch one division, check busy/hold behaviour each cycle, then score the result.
  task automatic run(input logic [5:0] a, input logic [5:0] b, input int idx, input bit inject);
    exp_t e;
    int   cyc;
    exp_t n;
    string t;
    t = $sformatf("idx%0d(%0d/%0d)", idx, a, b);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    n.q   = (b != 0) ? 6'(a / b) : 6'h3F;
    n.r   = (b != 0) ? 6'(a % b) : a;
    n.z   = (b == 0);
    n.idx = idx;
    sb.push_back(n);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = 6'($urandom);
    bus.divisor  = 6'($urandom);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc <= 12) begin
      chk({t, " busy"}, 16'(bus.busy), 16'((b != 0) && (cyc <= 6)));
      chk({t, " q_hold"}, 16'(bus.quotient), 16'(last_q));
      chk({t, " r_hold"}, 16'(bus.remainder), 16'(last_r));
      if (inject && cyc == 2) begin
        bus.start    = 1'b1;
        bus.dividend = 6'd60;
        bus.divisor  = 6'd2;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    chk({t, " latency"}, 16'(cyc), 16'((b != 0) ? 7 : 1));
    e = sb.pop_front();
    chk($sformatf("idx%0d quotient", e.idx), 16'(bus.quotient), 16'(e.q));
    chk($sformatf("idx%0d remainder", e.idx), 16'(bus.remainder), 16'(e.r));
    chk($sformatf("idx%0d div_by_zero", e.idx), 16'(bus.div_by_zero), 16'(e.z));
    chk($sformatf("idx%0d busy_at_done", e.idx), 16'(bus.busy), 16'd0);
    last_q = e.q;
    last_r = e.r;
    @(negedge clk);
    chk({t, " done_one_cycle"}, 16'(bus.done), 16'd0);
    chk({t, " q_after"}, 16'(bus.quotient), 16'(e.q));
  endtask

  initial begin
    int pulses;

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    run(6'd45, 6'd7, 1, 1'b0);
    run(6'd63, 6'd1, 2, 1'b0);
    run(6'd3, 6'd10, 3, 1'b0);
    run(6'd5, 6'd0, 4, 1'b0);
    run(6'd63, 6'd63, 5, 1'b0);

    // start during CALC must be ignored: one result, one pulse
    run(6'd45, 6'd7, 6, 1'b1);
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    chk("inject extra_done", 16'(pulses), 16'd0);

    // reset in the third CALC cycle aborts with no done pulse
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 6'd45;
    bus.divisor  = 6'd7;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort busy_before", 16'(bus.busy), 16'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("abort");
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    chk("abort done_pulses", 16'(pulses), 16'd0);
    last_q = '0;
    last_r = '0;

    // reset wins over start on the same edge
    bus.start    = 1'b1;
    bus.dividend = 6'd9;
    bus.divisor  = 6'd3;
    rst          = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    chk_all_zero("rst_start");
    @(negedge clk);
    chk("rst_start busy_next", 16'(bus.busy), 16'd0);

    run(6'd20, 6'd6, 7, 1'b0);

    for (int i = 0; i < 4096; i++) begin
      logic [11:0] v;
      v = 12'(i);
      run(v[11:6], v[5:0], i, 1'b0);
    end

    chk("scoreboard empty", 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
